load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the execute stage and data_memory. Turns RV32I load/store requests (funct3, byte
//  address, rs2 data) into word-addressed memory accesses with byte enables and lane-shifted write
//  data, then sign- or zero-extends the load result. Misaligned half/word accesses are split into
//  two word accesses. Memory has registered inputs, so read data appears 1 cycle after issue.
// PARAMETERS
//  MEM_ADDR_WIDTH    10  word-address width of data memory; wraps mod 2^MEM_ADDR_WIDTH
//  MISALIGNED_SPLIT  1   1: split misaligned accesses; 0: misaligned -> rsp_error, no memory access
// PORTS
//  clock        in   1   single clock; all state on rising edge
//  reset        in   1   synchronous, active-high
//  req_valid    in   1   request present
//  req_ready    out  1   high only in IDLE; request accepted on edge where valid&&ready
//  req_write    in   1   1 = store, 0 = load
//  req_funct3   in   3   RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  req_addr     in   32  byte address; bits [MEM_ADDR_WIDTH+1:2] used, upper bits ignored
//  req_wdata    in   32  store data, right-aligned (rs2)
//  rsp_valid    out  1   one-cycle pulse: request complete
//  rsp_rdata    out  32  extended load data; 0 for stores, errors, and whenever rsp_valid=0
//  rsp_error    out  1   illegal funct3 (or misaligned when MISALIGNED_SPLIT=0); valid with rsp_valid
//  mem_address  out  MEM_ADDR_WIDTH  word address to data memory
//  mem_byteena  out  4   byte enables
//  mem_data     out  32  lane-aligned write data
//  mem_wren     out  1   write enable
//  mem_q        in   32  read data, valid in the cycle after the address was presented
// BEHAVIOUR
//  - States: IDLE, ACC1, ACC2, FIN. Reset -> IDLE; request regs, lo_word cleared to 0.
//  - Reset values: req_ready=1 once in IDLE; rsp_valid=0, rsp_rdata=0, rsp_error=0, mem_wren=0,
//    mem_byteena=0, mem_address=0, mem_data=0. mem_wren is gated by !reset combinationally.
//  - IDLE: on accept, register write/funct3/addr/wdata. Illegal -> FIN with error, else -> ACC1.
//    Illegal: load funct3 011/110/111; store funct3 other than 000/001/010.
//  - Size mask: B=0001, H=0011, W=1111; off=addr[1:0]. lanes[7:0]=mask<<off;
//    wide[63:0]={32'b0,wdata}<<(8*off). misaligned = lanes[7:4]!=0 (H at off 3, W at off!=0).
//  - ACC1: mem_address=addr word, mem_byteena=lanes[3:0], mem_data=wide[31:0], mem_wren=write.
//    -> ACC2 if misaligned, else FIN.
//  - ACC2: mem_address=word+1 (wraps 2^MEM_ADDR_WIDTH-1 -> 0), mem_byteena=lanes[7:4],
//    mem_data=wide[63:32], mem_wren=write; load: mem_q (word 1) latched into lo_word. -> FIN.
//  - FIN: no memory access (byteena=0, wren=0); rsp_valid=1 for exactly 1 cycle; -> IDLE.
//    Load: cat={mem_q,lo_word} if misaligned else {32'b0,mem_q}; raw=cat>>(8*off);
//    LB/LH sign-extend raw[7:0]/raw[15:0], LBU/LHU zero-extend, LW raw[31:0].
//  - Latency accept edge -> rsp_valid: aligned 2 cycles, misaligned 3, illegal 1. Throughput:
//    next request accepted on the edge after FIN (IDLE cycle), no overlap.
//  - In IDLE and FIN all mem_* outputs are 0. rsp has no back-pressure; consumer must take pulse.
//  - Reset mid-operation: next edge -> IDLE, no rsp_valid, an ACC2 second write is abandoned.
// TESTING
//  - SW addr 0x10 data 0xDEADBEEF -> ACC1: mem_address=4, byteena=1111, data=0xDEADBEEF,
//    wren=1; rsp_valid 2 cycles after accept, rdata=0, error=0.
//  - LB addr 0x13, word4=0x80FF1234 -> rsp_rdata=0xFFFFFF80; LBU same -> 0x00000080.
//  - SH addr 0x0B data 0x0000ABCD -> ACC1 addr 2 be=1000 data 0xCD000000; ACC2 addr 3 be=0001
//    data 0x000000AB; LH 0x0B back -> 0xFFFFABCD, rsp_valid 3 cycles after accept.
//  - LW addr 0xFFE (word 1023, off 2): second access at word 0; word1023=0x22221111,
//    word0=0x44443333 -> rdata=0x33332222.
//  - Illegal load funct3=011 -> no mem access, rsp_valid 1 cycle after accept, error=1, rdata=0.
//  - Reset asserted in ACC1 of misaligned SW -> IDLE next edge, no ACC2 write, rsp_valid stays 0.

Source files
------------

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Bridges the execute stage and a word-addressed data memory. An RV32I
// load/store request (funct3, byte address, right-aligned rs2 data) becomes one
// or two word accesses with byte enables and lane-shifted write data. The load
// result is then shifted down and sign- or zero-extended. The memory registers
// its inputs, so read data for an address appears on mem_q one cycle later.
//
// Ports
//   clock, reset   single clock; synchronous active-high reset
//   req_valid      request present
//   req_ready      high in IDLE only; accept on valid && ready
//   req_write      1 = store, 0 = load
//   req_funct3     RV32I funct3
//   req_addr       byte address (bits [MEM_ADDR_WIDTH+1:0] used)
//   req_wdata      store data, right-aligned
//   rsp_valid      one-cycle completion pulse
//   rsp_rdata      extended load data (0 unless a successful load completes)
//   rsp_error      illegal funct3 / unsupported misalignment, with rsp_valid
//   mem_address    word address to data memory
//   mem_byteena    byte enables
//   mem_data       lane-aligned write data
//   mem_wren       write enable (forced low while reset is asserted)
//   mem_q          memory read data, one cycle after the address
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int MEM_ADDR_WIDTH   = 10,
  parameter bit MISALIGNED_SPLIT = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [2:0]                req_funct3,
  input  logic [31:0]               req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_error,
  output logic [MEM_ADDR_WIDTH-1:0] mem_address,
  output logic [3:0]                mem_byteena,
  output logic [31:0]               mem_data,
  output logic                      mem_wren,
  input  logic [31:0]               mem_q
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC1 = 2'd1;
  localparam logic [1:0] S_ACC2 = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  // Byte mask for the access size encoded in funct3[1:0].
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Byte lanes touched across two consecutive words; bits [7:4] set means
  // the access spills into the following word.
  function automatic logic [7:0] lane_map(input logic [1:0] sz, input logic [1:0] off);
    return {4'b0000, size_mask(sz)} << off;
  endfunction

  function automatic logic is_legal(input logic wr, input logic [2:0] f3);
    if (wr)
      return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    else
      return !((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
  endfunction

  // -------------------------------------------------------------------------
  // State and request registers
  // -------------------------------------------------------------------------
  logic [1:0]                state_reg, state_next;
  logic                      write_reg;
  logic [2:0]                funct3_reg;
  logic [MEM_ADDR_WIDTH+1:0] addr_reg;
  logic [31:0]               wdata_reg;
  logic [31:0]               lo_word_reg;
  logic                      error_reg;

  // Upper address bits are outside the memory and deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:MEM_ADDR_WIDTH+2];

  // Decode of the incoming request (used only on the accept edge).
  logic [7:0] in_lanes;
  logic       in_misaligned;
  logic       in_error;
  logic       accept;

  assign accept        = req_valid && (state_reg == S_IDLE);
  assign in_lanes      = lane_map(req_funct3[1:0], req_addr[1:0]);
  assign in_misaligned = |in_lanes[7:4];
  assign in_error      = !is_legal(req_write, req_funct3) || (in_misaligned && !MISALIGNED_SPLIT);

  // Decode of the registered request.
  logic [1:0]                off;
  logic [MEM_ADDR_WIDTH-1:0] word_addr;
  logic [7:0]                lanes;
  logic                      misaligned;

  assign off        = addr_reg[1:0];
  assign word_addr  = addr_reg[MEM_ADDR_WIDTH+1:2];
  assign lanes      = lane_map(funct3_reg[1:0], off);
  assign misaligned = |lanes[7:4];

  // -------------------------------------------------------------------------
  // Store data: wdata shifted up by off bytes into a 64-bit two-word window.
  // -------------------------------------------------------------------------
  logic [63:0] wide;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_wide
      logic [2:0] sel;
      assign sel = 3'(gi) - {1'b0, off};
      assign wide[8*gi +: 8] = ((3'(gi) >= {1'b0, off}) && (sel < 3'd4))
                               ? wdata_reg[{sel[1:0], 3'b000} +: 8] : 8'h00;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Load data: two-word window shifted down by off bytes.
  // When the access was split, lo_word holds the first word and mem_q the
  // second; otherwise mem_q alone carries the data.
  // -------------------------------------------------------------------------
  logic [63:0] cat;
  logic [7:0]  cat_bytes [8];
  logic [31:0] load_raw;
  logic [31:0] load_ext;

  assign cat = misaligned ? {mem_q, lo_word_reg} : {32'h0, mem_q};

  generate
    for (gi = 0; gi < 8; gi++) begin : g_cat
      assign cat_bytes[gi] = cat[8*gi +: 8];
    end
    for (gi = 0; gi < 4; gi++) begin : g_raw
      assign load_raw[8*gi +: 8] = cat_bytes[3'(gi) + {1'b0, off}];
    end
  endgenerate

  always_comb begin
    load_ext = load_raw;
    case (funct3_reg)
      3'b000:  load_ext = {{24{load_raw[7]}},  load_raw[7:0]};
      3'b001:  load_ext = {{16{load_raw[15]}}, load_raw[15:0]};
      3'b100:  load_ext = {24'h0, load_raw[7:0]};
      3'b101:  load_ext = {16'h0, load_raw[15:0]};
      default: load_ext = load_raw;
    endcase
  end

  // -------------------------------------------------------------------------
  // Next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (req_valid) state_next = in_error ? S_FIN : S_ACC1;
      S_ACC1: state_next = misaligned ? S_ACC2 : S_FIN;
      S_ACC2: state_next = S_FIN;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      write_reg   <= 1'b0;
      funct3_reg  <= 3'b000;
      addr_reg    <= '0;
      wdata_reg   <= 32'h0;
      lo_word_reg <= 32'h0;
      error_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        write_reg  <= req_write;
        funct3_reg <= req_funct3;
        addr_reg   <= req_addr[MEM_ADDR_WIDTH+1:0];
        wdata_reg  <= req_wdata;
        error_reg  <= in_error;
      end
      // First word of a split load arrives while the second is addressed.
      if ((state_reg == S_ACC2) && !write_reg)
        lo_word_reg <= mem_q;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: all mem_* idle in IDLE and FIN, response only in FIN.
  // -------------------------------------------------------------------------
  always_comb begin
    req_ready   = (state_reg == S_IDLE);
    rsp_valid   = 1'b0;
    rsp_rdata   = 32'h0;
    rsp_error   = 1'b0;
    mem_address = '0;
    mem_byteena = 4'b0000;
    mem_data    = 32'h0;
    mem_wren    = 1'b0;
    case (state_reg)
      S_ACC1: begin
        mem_address = word_addr;
        mem_byteena = lanes[3:0];
        mem_data    = wide[31:0];
        mem_wren    = write_reg && !reset;
      end
      S_ACC2: begin
        // Word address wraps naturally at the memory size.
        mem_address = word_addr + MEM_ADDR_WIDTH'(1);
        mem_byteena = lanes[7:4];
        mem_data    = wide[63:32];
        mem_wren    = write_reg && !reset;
      end
      S_FIN: begin
        rsp_valid = 1'b1;
        rsp_error = error_reg;
        rsp_rdata = (!write_reg && !error_reg) ? load_ext : 32'h0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit with a behavioural registered-input
// data memory. Expected memory accesses and responses are queued when a
// request is issued; a monitor on the falling edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [9:0]  mem_address;
  logic [3:0]  mem_byteena;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q;

  always #5 clock = ~clock;

  load_store_unit #(
    .MEM_ADDR_WIDTH  (10),
    .MISALIGNED_SPLIT(1'b1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .mem_address(mem_address),
    .mem_byteena(mem_byteena),
    .mem_data   (mem_data),
    .mem_wren   (mem_wren),
    .mem_q      (mem_q)
  );

  // Behavioural data memory: registered address, read data one cycle later.
  logic [31:0] mem [1024];

  always @(posedge clock) begin
    mem_q <= mem[mem_address];
    if (mem_wren)
      for (int b = 0; b < 4; b++)
        if (mem_byteena[b]) mem[mem_address][8*b +: 8] <= mem_data[8*b +: 8];
  end

  typedef struct packed {
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic        wren;
  } acc_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  lat;
  } rsp_t;

  acc_t acc_q[$];
  rsp_t rsp_q[$];

  int n_vec  = 0;
  int n_miss = 0;
  int n_rsp  = 0;
  int cyc    = 99;
  bit mon_en = 1'b0;
  bit acc_chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void exp_acc(input logic [9:0] a, input logic [3:0] be,
                                  input logic [31:0] d, input logic w);
    acc_q.push_back('{addr: a, be: be, data: d, wren: w});
  endfunction

  function automatic void exp_rsp(input logic [31:0] r, input logic e, input logic [3:0] l);
    rsp_q.push_back('{rdata: r, err: e, lat: l});
  endfunction

  // Monitor: responses, memory accesses, idle quietness, latency tracking.
  always @(negedge clock) begin
    if (mon_en) begin
      if (rsp_valid) begin
        n_rsp++;
        $display("rsp %0d: rdata=%h err=%b lat=%0d", n_rsp, rsp_rdata, rsp_error, cyc);
        if (rsp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_rsp: got rdata %h err %b, required no response", rsp_rdata, rsp_error);
        end else begin
          rsp_t e;
          e = rsp_q.pop_front();
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          chk("rsp_error", 64'(rsp_error), 64'(e.err));
          chk("rsp_latency", 64'(cyc), 64'(e.lat));
        end
      end else begin
        chk("rdata_when_idle", 64'(rsp_rdata), 64'h0);
      end

      if (acc_chk_en) begin
        if ((mem_byteena != 4'b0000) || mem_wren) begin
          if (acc_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_access: got addr %0d be %b data %h wren %b, required none",
                     mem_address, mem_byteena, mem_data, mem_wren);
          end else begin
            acc_t a;
            a = acc_q.pop_front();
            chk("mem_address", 64'(mem_address), 64'(a.addr));
            chk("mem_byteena", 64'(mem_byteena), 64'(a.be));
            chk("mem_data",    64'(mem_data),    64'(a.data));
            chk("mem_wren",    64'(mem_wren),    64'(a.wren));
          end
        end else if (req_ready || rsp_valid) begin
          chk("mem_quiet", 64'({mem_address, mem_byteena, mem_data, mem_wren}), 64'h0);
        end
      end

      if (req_valid && req_ready) cyc = 1;
      else if (cyc < 15) cyc++;
    end
  end

  // Present one request (called just after a rising edge) and return right
  // after the edge on which it is accepted.
  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    int t;
    t = 0;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    req_valid  = 1'b1;
    while (!req_ready && t < 50) begin
      @(posedge clock);
      #1;
      t++;
    end
    if (!req_ready) begin
      n_vec++;
      n_miss++;
      $display("FAIL req_ready_timeout: got ready 0 after %0d cycles, required 1", t);
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((rsp_q.size() != 0 || acc_q.size() != 0) && t < 30) begin
      @(posedge clock);
      #1;
      t++;
    end
    if (rsp_q.size() != 0 || acc_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL completion_timeout: got %0d rsp and %0d acc pending, required 0",
               rsp_q.size(), acc_q.size());
      rsp_q.delete();
      acc_q.delete();
    end
  endtask

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_wren", 64'(mem_wren), 64'h0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset_ready", 64'(req_ready), 64'h1);
    @(posedge clock);
    #1;
    reset      = 1'b0;
    mon_en     = 1'b1;
    acc_chk_en = 1'b1;
    @(negedge clock);
    chk("idle_ready", 64'(req_ready), 64'h1);
    chk("idle_outputs", 64'({rsp_valid, rsp_error, rsp_rdata}), 64'h0);
    chk("idle_mem", 64'({mem_address, mem_byteena, mem_data, mem_wren}), 64'h0);
    @(posedge clock);
    #1;

    // Aligned word store
    exp_acc(10'd4, 4'b1111, 32'hDEADBEEF, 1'b1); exp_rsp(32'h0, 1'b0, 4'd2);
    issue(1'b1, F_W, 32'h10, 32'hDEADBEEF); wait_done();
    exp_acc(10'd4, 4'b1111, 32'h80FF1234, 1'b1); exp_rsp(32'h0, 1'b0, 4'd2);
    issue(1'b1, F_W, 32'h10, 32'h80FF1234); wait_done();

    // Aligned loads from word 4 = 0x80FF1234
    exp_acc(10'd4, 4'b1000, 32'h0, 1'b0); exp_rsp(32'hFFFFFF80, 1'b0, 4'd2);
    issue(1'b0, F_B, 32'h13, 32'h0); wait_done();
    exp_acc(10'd4, 4'b1000, 32'h0, 1'b0); exp_rsp(32'h00000080, 1'b0, 4'd2);
    issue(1'b0, F_BU, 32'h13, 32'h0); wait_done();
    exp_acc(10'd4, 4'b1100, 32'h0, 1'b0); exp_rsp(32'hFFFF80FF, 1'b0, 4'd2);
    issue(1'b0, F_H, 32'h12, 32'h0); wait_done();
    exp_acc(10'd4, 4'b1100, 32'h0, 1'b0); exp_rsp(32'h000080FF, 1'b0, 4'd2);
    issue(1'b0, F_HU, 32'h12, 32'h0); wait_done();
    exp_acc(10'd4, 4'b1111, 32'h0, 1'b0); exp_rsp(32'h80FF1234, 1'b0, 4'd2);
    issue(1'b0, F_W, 32'h10, 32'h0); wait_done();
    exp_acc(10'd4, 4'b0001, 32'h0, 1'b0); exp_rsp(32'h00000034, 1'b0, 4'd2);
    issue(1'b0, F_B, 32'h10, 32'h0); wait_done();

    // Misaligned halfword store and load across words 2/3
    exp_acc(10'd2, 4'b1000, 32'hCD000000, 1'b1);
    exp_acc(10'd3, 4'b0001, 32'h000000AB, 1'b1); exp_rsp(32'h0, 1'b0, 4'd3);
    issue(1'b1, F_H, 32'h0B, 32'h0000ABCD); wait_done();
    exp_acc(10'd2, 4'b1000, 32'h0, 1'b0);
    exp_acc(10'd3, 4'b0001, 32'h0, 1'b0); exp_rsp(32'hFFFFABCD, 1'b0, 4'd3);
    issue(1'b0, F_H, 32'h0B, 32'h0); wait_done();

    // Word load wrapping from word 1023 to word 0
    exp_acc(10'd1023, 4'b1111, 32'h22221111, 1'b1); exp_rsp(32'h0, 1'b0, 4'd2);
    issue(1'b1, F_W, 32'hFFC, 32'h22221111); wait_done();
    exp_acc(10'd0, 4'b1111, 32'h44443333, 1'b1); exp_rsp(32'h0, 1'b0, 4'd2);
    issue(1'b1, F_W, 32'h000, 32'h44443333); wait_done();
    exp_acc(10'd1023, 4'b1100, 32'h0, 1'b0);
    exp_acc(10'd0, 4'b0011, 32'h0, 1'b0); exp_rsp(32'h33332222, 1'b0, 4'd3);
    issue(1'b0, F_W, 32'hFFE, 32'h0); wait_done();

    // Byte store ignores upper rs2 bits on the enabled lane
    exp_acc(10'd8, 4'b0010, 32'h34565A00, 1'b1); exp_rsp(32'h0, 1'b0, 4'd2);
    issue(1'b1, F_B, 32'h21, 32'h1234565A); wait_done();
    exp_acc(10'd8, 4'b0010, 32'h0, 1'b0); exp_rsp(32'h0000005A, 1'b0, 4'd2);
    issue(1'b0, F_BU, 32'h21, 32'h0); wait_done();
    exp_acc(10'd8, 4'b1111, 32'h0, 1'b0); exp_rsp(32'h00005A00, 1'b0, 4'd2);
    issue(1'b0, F_W, 32'h20, 32'h0); wait_done();

    // Illegal encodings: no memory access, error after one cycle
    exp_rsp(32'h0, 1'b1, 4'd1);
    issue(1'b0, 3'b011, 32'h10, 32'h0); wait_done();
    exp_rsp(32'h0, 1'b1, 4'd1);
    issue(1'b0, 3'b110, 32'h10, 32'h0); wait_done();
    exp_rsp(32'h0, 1'b1, 4'd1);
    issue(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF); wait_done();

    // Reset during ACC1 of a misaligned word store at word 5
    acc_chk_en = 1'b0;
    issue(1'b1, F_W, 32'h15, 32'h11223344);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_acc1_byteena", 64'(mem_byteena), 64'h0E);
    chk("rst_acc1_wren_gated", 64'(mem_wren), 64'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    acc_chk_en = 1'b1;
    chk("rst_back_to_idle", 64'(req_ready), 64'h1);
    repeat (4) @(negedge clock);
    chk("rst_word5_untouched", 64'(mem[5]), 64'h0);
    chk("rst_word6_untouched", 64'(mem[6]), 64'h0);
    @(posedge clock);
    #1;
    exp_acc(10'd5, 4'b1111, 32'h0, 1'b0); exp_rsp(32'h0, 1'b0, 4'd2);
    issue(1'b0, F_W, 32'h14, 32'h0); wait_done();

    // Misaligned word store/load across words 5/6
    exp_acc(10'd5, 4'b1110, 32'h22334400, 1'b1);
    exp_acc(10'd6, 4'b0001, 32'h00000011, 1'b1); exp_rsp(32'h0, 1'b0, 4'd3);
    issue(1'b1, F_W, 32'h15, 32'h11223344); wait_done();
    exp_acc(10'd5, 4'b1110, 32'h0, 1'b0);
    exp_acc(10'd6, 4'b0001, 32'h0, 1'b0); exp_rsp(32'h11223344, 1'b0, 4'd3);
    issue(1'b0, F_W, 32'h15, 32'h0); wait_done();

    repeat (3) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
